// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_flags
//  Purpose  : Single-clock FIFO with occupancy count, programmable
//             almost-full / almost-empty thresholds and overflow / underflow
//             error pulses. Read port is either standard (registered read,
//             one-cycle latency) or first-word-fall-through.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1           clock, rising edge
//    rst_n           in   1           asynchronous reset, active low
//    din_i           in   DATA_WIDTH  write data
//    wen_i           in   1           write request
//    ren_i           in   1           read request
//    dout_o          out  DATA_WIDTH  read data
//    dout_valid_o    out  1           dout_o holds a valid word
//    full_o          out  1           data_count_o == DATA_DEPTH
//    empty_o         out  1           no word available to read
//    almost_full_o   out  1           data_count_o >= AF_THRESH
//    almost_empty_o  out  1           data_count_o <= AE_THRESH
//    data_count_o    out  CNT_W       words held, 0..DATA_DEPTH
//    overflow_o      out  1           pulse: write requested while full
//    underflow_o     out  1           pulse: read requested while empty
// ============================================================================
module fifo_sync_flags #(
    parameter int    DATA_WIDTH = 32,
    parameter int    DATA_DEPTH = 512,
    parameter string MODE       = "STD",
    parameter int    AF_THRESH  = DATA_DEPTH - 8,
    parameter int    AE_THRESH  = 8,
    localparam int   CNT_W      = $clog2(DATA_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  wen_i,
    input  logic                  ren_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  dout_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CNT_W-1:0]      data_count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int               PTR_W    = $clog2(DATA_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DATA_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DATA_DEPTH);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_THRESH);
    localparam bit               IS_FWFT  = (MODE == "FWFT");

    // Storage is not reset: contents are meaningless once the count is zero.
    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic [DATA_WIDTH-1:0] dout_q,   dout_d;
    logic                  dv_q,     dv_d;
    logic                  full_q,   empty_q, af_q, ae_q;
    logic                  ovf_q,    udf_q;

    logic                  wr_acc;
    logic                  rd_acc;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Acceptance uses the registered flags, so both-while-full pops only and
    // both-while-empty pushes only.
    always_comb begin
        wr_acc   = wen_i & ~full_q;
        rd_acc   = ren_i & ~empty_q;
        wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    generate
        if (IS_FWFT) begin : g_fwft
            logic [DATA_WIDTH-1:0] head;
            // The post-edge head is being written this very edge only when the
            // write pointer lands on it (write into empty, or pop of the last
            // word with a simultaneous push); forward din in that case.
            always_comb begin
                head = mem_q[rd_ptr_d];
                if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
                    head = din_i;
                end
                dv_d   = (count_d != '0);
                dout_d = dv_d ? head : dout_q;
            end
        end else begin : g_std
            always_comb begin
                dv_d   = rd_acc;
                dout_d = rd_acc ? mem_q[rd_ptr_q] : dout_q;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
            // Flags derive from the next count so they never lag data_count.
            full_q   <= (count_d == DEPTH_C);
            empty_q  <= (count_d == '0);
            af_q     <= (count_d >= AF_C);
            ae_q     <= (count_d <= AE_C);
            ovf_q    <= wen_i & full_q;
            udf_q    <= ren_i & empty_q;
        end
    end

    assign dout_o         = dout_q;
    assign dout_valid_o   = dv_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign data_count_o   = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_flags.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_sync_flags
//  Purpose  : Directed self-checking bench for fifo_sync_flags. One STD and
//             one FWFT instance share the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_flags;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          wen = 1'b0;
    logic          ren = 1'b0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_dv, f_dv, s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_udf, f_udf;
    logic [CW-1:0] s_cnt, f_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_sync_flags #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .MODE("STD"),
                      .AF_THRESH(14), .AE_THRESH(2)) u_std (
        .clk(clk), .rst_n(rst_n), .din_i(din), .wen_i(wen), .ren_i(ren),
        .dout_o(s_dout), .dout_valid_o(s_dv), .full_o(s_full), .empty_o(s_empty),
        .almost_full_o(s_af), .almost_empty_o(s_ae), .data_count_o(s_cnt),
        .overflow_o(s_ovf), .underflow_o(s_udf));

    fifo_sync_flags #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .MODE("FWFT"),
                      .AF_THRESH(14), .AE_THRESH(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .din_i(din), .wen_i(wen), .ren_i(ren),
        .dout_o(f_dout), .dout_valid_o(f_dv), .full_o(f_full), .empty_o(f_empty),
        .almost_full_o(f_af), .almost_empty_o(f_ae), .data_count_o(f_cnt),
        .overflow_o(f_ovf), .underflow_o(f_udf));

    typedef struct {
        logic          wen;
        logic          ren;
        logic [DW-1:0] din;
        int            cnt;
        logic          full, empty, af, ae, ovf, udf;
        logic          sdv;
        logic [DW-1:0] sdout;
        logic          fdv;
        logic [DW-1:0] fdout;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Flag/count checks applied to both instances.
    task automatic chk_state(input string tag, input int cnt, input logic full,
                             input logic empty, input logic af, input logic ae,
                             input logic ovf, input logic udf);
        chk({tag, " s_cnt"},   DW'(s_cnt), DW'(cnt));
        chk({tag, " f_cnt"},   DW'(f_cnt), DW'(cnt));
        chk({tag, " full"},    DW'(s_full),  DW'(full));
        chk({tag, " empty"},   DW'(s_empty), DW'(empty));
        chk({tag, " f_empty"}, DW'(f_empty), DW'(empty));
        chk({tag, " af"},      DW'(s_af),    DW'(af));
        chk({tag, " ae"},      DW'(s_ae),    DW'(ae));
        chk({tag, " ovf"},     DW'(s_ovf),   DW'(ovf));
        chk({tag, " f_ovf"},   DW'(f_ovf),   DW'(ovf));
        chk({tag, " udf"},     DW'(s_udf),   DW'(udf));
        chk({tag, " f_udf"},   DW'(f_udf),   DW'(udf));
    endtask

    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
        wen = w;
        ren = r;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic w, input logic r, input logic [DW-1:0] d,
                           input int cnt, input logic ovf, input logic udf,
                           input logic sdv, input logic [DW-1:0] sdout,
                           input logic fdv, input logic [DW-1:0] fdout);
        vec_t v;
        v.wen = w; v.ren = r; v.din = d; v.cnt = cnt;
        v.full = (cnt == 16); v.empty = (cnt == 0);
        v.af = (cnt >= 14);   v.ae = (cnt <= 2);
        v.ovf = ovf; v.udf = udf;
        v.sdv = sdv; v.sdout = sdout; v.fdv = fdv; v.fdout = fdout;
        vecs.push_back(v);
    endtask

    initial begin
        // ---------------- vector table: fill, overflow, drain, underflow ------
        for (int i = 0; i < 16; i++)
            add_vec(1, 0, DW'(5 * (i + 1)), i + 1, 0, 0, 0, 0, 1, 5);
        add_vec(1, 0, 85, 16, 1, 0, 0, 0, 1, 5);
        add_vec(0, 0, 0, 16, 0, 0, 0, 0, 1, 5);
        for (int j = 0; j < 16; j++)
            add_vec(0, 1, 0, 15 - j, 0, 0, 1, DW'(5 * (j + 1)), (j < 15), DW'(5 * (j + 2)));
        add_vec(0, 1, 0, 0, 0, 1, 0, 80, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 80, 0, 0);

        // ---------------- 1: reset mid-burst ----------------------------------
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk_state("rst0", 0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, DW'(i + 1));
            if (i == 2) begin
                chk("burst s_cnt", DW'(s_cnt), 3);
                #2 rst_n = 1'b0;
                #1;
                chk_state("async_rst", 0, 0, 1, 0, 1, 0, 0);
                chk("async_rst s_dout", s_dout, 0);
                chk("async_rst f_dout", f_dout, 0);
                chk("async_rst s_dv",   DW'(s_dv), 0);
                chk("async_rst f_dv",   DW'(f_dv), 0);
                break;
            end
        end
        wen = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_state("post_rst", 0, 0, 1, 0, 1, 0, 0);

        // ---------------- 2/3: table-driven fill and drain --------------------
        foreach (vecs[k]) begin
            cyc(vecs[k].wen, vecs[k].ren, vecs[k].din);
            chk_state($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].full, vecs[k].empty,
                      vecs[k].af, vecs[k].ae, vecs[k].ovf, vecs[k].udf);
            chk($sformatf("vec%0d s_dv", k),   DW'(s_dv), DW'(vecs[k].sdv));
            chk($sformatf("vec%0d s_dout", k), s_dout, vecs[k].sdout);
            chk($sformatf("vec%0d f_dv", k),   DW'(f_dv), DW'(vecs[k].fdv));
            if (vecs[k].fdv)
                chk($sformatf("vec%0d f_dout", k), f_dout, vecs[k].fdout);
        end

        // ---------------- 4: FWFT single word ---------------------------------
        cyc(1, 0, 32'hA5);
        cyc(0, 0, 0);
        chk("fwft dout", f_dout, 32'hA5);
        chk("fwft dv",   DW'(f_dv), 1);
        chk_state("fwft1", 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0);
        chk_state("fwft_pop", 0, 0, 1, 0, 1, 0, 0);
        chk("fwft_pop dv", DW'(f_dv), 0);
        chk("std_pop dout", s_dout, 32'hA5);

        // ---------------- 5: simultaneous read/write --------------------------
        for (int i = 1; i <= 16; i++) cyc(1, 0, DW'(i));
        chk_state("full16", 16, 1, 0, 1, 0, 0, 0);
        cyc(1, 1, 32'h99);
        chk_state("both_full", 15, 0, 0, 1, 0, 1, 0);
        chk("both_full s_dout", s_dout, 1);
        chk("both_full s_dv",   DW'(s_dv), 1);
        chk("both_full f_dout", f_dout, 2);
        for (int k = 0; k < 15; k++) begin
            cyc(0, 1, 0);
            chk($sformatf("drain15 s_dout%0d", k), s_dout, DW'(k + 2));
        end
        chk_state("drained", 0, 0, 1, 0, 1, 0, 0);
        cyc(1, 1, 32'h77);
        chk_state("both_empty", 1, 0, 0, 0, 1, 0, 1);
        chk("both_empty s_dv",   DW'(s_dv), 0);
        chk("both_empty f_dout", f_dout, 32'h77);
        chk("both_empty f_dv",   DW'(f_dv), 1);
        for (int i = 0; i < 7; i++) cyc(1, 0, DW'(32'h78 + i));
        chk_state("cnt8", 8, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'h7F);
        chk_state("both_mid", 8, 0, 0, 0, 0, 0, 0);
        chk("both_mid s_dout", s_dout, 32'h77);
        chk("both_mid f_dout", f_dout, 32'h78);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 0);
            chk($sformatf("order s_dout%0d", k), s_dout, DW'(32'h78 + k));
        end
        chk_state("empty_again", 0, 0, 1, 0, 1, 0, 0);

        // ---------------- 6: streaming through pointer wrap -------------------
        for (int i = 1; i <= 3; i++) cyc(1, 0, DW'(5 * i));
        for (int k = 0; k < 40; k++) begin
            cyc(1, 1, DW'(20 + 5 * k));
            chk_state($sformatf("wrap%0d", k), 3, 0, 0, 0, 0, 0, 0);
            chk($sformatf("wrap%0d s_dout", k), s_dout, DW'(5 * (k + 1)));
            chk($sformatf("wrap%0d f_dout", k), f_dout, DW'(5 * (k + 2)));
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0);
            chk($sformatf("tail s_dout%0d", k), s_dout, DW'(205 + 5 * k));
        end
        chk_state("final", 0, 0, 1, 0, 1, 0, 0);
        wen = 0;
        ren = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
